// File: rtl/hdmi_init_sequencer.sv
// hdmi_init_sequencer
// Walks a ROM table of HDMI transmitter register writes and issues each one
// to a shared I2C write master once the power-on delay has elapsed and a sink
// is present. A NACKed write is retried after a fixed backoff, up to a bounded
// number of attempts. The whole table is re-run on every hot-plug.
//
// Ports:
//   clock       pixel clock
//   reset       asynchronous active-low reset
//   ready       startup delay elapsed (level, synchronous to clock)
//   hpd         hot-plug detect (asynchronous, synchronized here)
//   tbl_addr    table index to the external ROM
//   tbl_rdata   ROM data {reg[15:8], value[7:0]}, valid one cycle after tbl_addr
//   wr_valid    write request to the I2C master
//   wr_reg      register address, stable while wr_valid
//   wr_data     register value, stable while wr_valid
//   wr_done     one-cycle completion pulse from the master
//   wr_nack     qualifies wr_done: slave NACKed
//   init_done   whole table written and sink present
//   init_error  an entry exhausted its attempts
module hdmi_init_sequencer #(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned RETRY_DELAY = 1000,
    localparam int unsigned AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ready,
    input  logic          hpd,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_rdata,
    output logic          wr_valid,
    output logic [7:0]    wr_reg,
    output logic [7:0]    wr_data,
    input  logic          wr_done,
    input  logic          wr_nack,
    output logic          init_done,
    output logic          init_error
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned BW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_WRITE,
        S_WAIT_DONE,
        S_BACKOFF,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   index;
    logic [AW-1:0]   index_next;
    logic [RW-1:0]   retry_cnt;
    logic [RW-1:0]   retry_next;
    logic [RW-1:0]   retry_inc;
    logic [BW-1:0]   bcnt;
    logic [BW-1:0]   bcnt_next;
    logic            abort;
    logic            abort_next;
    logic            wr_valid_next;
    logic [7:0]      wr_reg_next;
    logic [7:0]      wr_data_next;
    logic            hpd_meta;
    logic            hpd_s;
    logic            go;
    logic            last_entry;

    // Two-flop synchronizer for the asynchronous hot-plug detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hpd_meta <= 1'b0;
            hpd_s    <= 1'b0;
        end else begin
            hpd_meta <= hpd;
            hpd_s    <= hpd_meta;
        end
    end

    assign go         = ready & hpd_s;
    assign retry_inc  = retry_cnt + RW'(1);
    assign last_entry = (index == AW'(NUM_ENTRIES - 1));

    // The table index doubles as the ROM address; it is already settled
    // while in FETCH so the ROM data is valid during WAIT_ROM.
    assign tbl_addr = index;

    // State, counters and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            index      <= '0;
            retry_cnt  <= '0;
            bcnt       <= '0;
            abort      <= 1'b0;
            wr_valid   <= 1'b0;
            wr_reg     <= 8'h00;
            wr_data    <= 8'h00;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            retry_cnt  <= retry_next;
            bcnt       <= bcnt_next;
            abort      <= abort_next;
            wr_valid   <= wr_valid_next;
            wr_reg     <= wr_reg_next;
            wr_data    <= wr_data_next;
            init_done  <= (state_next == S_DONE);
            init_error <= (state_next == S_FAIL);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state;
        index_next    = index;
        retry_next    = retry_cnt;
        bcnt_next     = bcnt;
        abort_next    = abort;
        wr_valid_next = 1'b0;
        wr_reg_next   = wr_reg;
        wr_data_next  = wr_data;

        case (state)
            S_IDLE: begin
                index_next = '0;
                retry_next = '0;
                abort_next = 1'b0;
                if (go) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                state_next = go ? S_WAIT_ROM : S_IDLE;
            end

            S_WAIT_ROM: begin
                if (!go) begin
                    state_next = S_IDLE;
                end else begin
                    wr_reg_next  = tbl_rdata[15:8];
                    wr_data_next = tbl_rdata[7:0];
                    state_next   = S_WRITE;
                end
            end

            S_WRITE: begin
                if (!go) begin
                    state_next = S_IDLE;
                end else begin
                    wr_valid_next = 1'b1;
                    state_next    = S_WAIT_DONE;
                end
            end

            // An in-flight write is always seen to completion; a loss of go
            // is remembered and honoured once the master reports done.
            S_WAIT_DONE: begin
                if (!go) begin
                    abort_next = 1'b1;
                end
                if (!wr_done) begin
                    wr_valid_next = 1'b1;
                end else if (abort || !go) begin
                    state_next = S_IDLE;
                end else if (!wr_nack) begin
                    retry_next = '0;
                    if (last_entry) begin
                        state_next = S_DONE;
                    end else begin
                        index_next = index + AW'(1);
                        state_next = S_FETCH;
                    end
                end else begin
                    retry_next = retry_inc;
                    if (retry_inc == RW'(MAX_RETRIES)) begin
                        state_next = S_FAIL;
                    end else begin
                        bcnt_next  = '0;
                        state_next = S_BACKOFF;
                    end
                end
            end

            // wr_valid is raised on the edge that leaves BACKOFF so the bus
            // sees exactly RETRY_DELAY idle cycles between attempts.
            S_BACKOFF: begin
                if (!go) begin
                    state_next = S_IDLE;
                end else if (bcnt == BW'(RETRY_DELAY - 1)) begin
                    wr_valid_next = 1'b1;
                    state_next    = S_WRITE;
                end else begin
                    bcnt_next = bcnt + BW'(1);
                end
            end

            S_DONE: begin
                if (!go) begin
                    state_next = S_IDLE;
                end
            end

            S_FAIL: begin
                if (!go) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/hdmi_init_sequencer.md
Name: hdmi_init_sequencer

Overview:
- Downstream consumer of the startup-delay block's `ready` output.
- Once the power-on delay has elapsed and a sink is present (HPD high), walks a register table of HDMI transmitter config writes and issues each one to the shared I2C write master.
- Single-write valid/done handshake; bounded retry with backoff on NACK; re-runs the whole table on every hot-plug.
- Reports `init_done` / `init_error` to the video pipeline.

Parameters:
- NUM_ENTRIES, 32, number of table entries; valid range 1..256.
- MAX_RETRIES, 3, total attempts per entry (first try included) before FAIL.
- RETRY_DELAY, 1000, idle clock cycles between a NACK and the next attempt; must be ≥1.

Ports:
- clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- ready  in  1  from startup-delay block; synchronous to `clock`, level.
- hpd  in  1  hot-plug detect, asynchronous to `clock`; 2-flop synchronized internally.
- tbl_addr  out  $clog2(NUM_ENTRIES) (min 1)  table index to external ROM.
- tbl_rdata  in  16  ROM data: [15:8] register address, [7:0] value; valid 1 cycle after `tbl_addr`.
- wr_valid  out  1  write request to I2C master.
- wr_reg  out  8  register address, stable while `wr_valid`.
- wr_data  out  8  register value, stable while `wr_valid`.
- wr_done  in  1  1-cycle pulse from master: transaction finished.
- wr_nack  in  1  qualifies `wr_done`: 1 = slave NACKed.
- init_done  out  1  table fully written, sink present.
- init_error  out  1  an entry exhausted MAX_RETRIES.

Behaviour:
- Reset values: `wr_valid`=0, `wr_reg`=0, `wr_data`=0, `tbl_addr`=0, `init_done`=0, `init_error`=0, state=IDLE, index=0, retry_cnt=0, hpd sync flops=0.
- `go` = ready && hpd_s, where hpd_s is the 2-flop synchronized `hpd`.

State machine:
- IDLE: index←0, retry_cnt←0. Goes to FETCH when `go`=1.
- FETCH: `tbl_addr`=index. Goes to WAIT_ROM.
- WAIT_ROM: latch `tbl_rdata` into `wr_reg`/`wr_data`. Goes to WRITE.
- WRITE: `wr_valid`=1. Goes to WAIT_DONE.
- WAIT_DONE:
  - `wr_valid` stays 1 until the cycle `wr_done`=1 is sampled; it is deasserted from the next cycle.
  - `wr_nack`=0:
    - retry_cnt←0.
    - If index==NUM_ENTRIES-1, go to DONE.
    - Otherwise index←index+1 and go to FETCH.
  - `wr_nack`=1:
    - retry_cnt←retry_cnt+1.
    - If the new value equals MAX_RETRIES, go to FAIL.
    - Otherwise go to BACKOFF.
- BACKOFF: count RETRY_DELAY cycles, then go to WRITE with the same latched `wr_reg`/`wr_data`; the ROM is not re-read.
- DONE: `init_done`=1.
- FAIL: `init_error`=1.

Timing:
- `wr_valid` rises on the 3rd clock edge after the edge on which `go` is first sampled high.
- `hpd` adds 2 cycles of synchronizer latency ahead of `go`.

Abort rules:
- `go`=0 in IDLE, FETCH, WAIT_ROM, WRITE or BACKOFF: go to IDLE next cycle; `wr_valid` drops.
- `go`=0 in WAIT_DONE: an in-flight write is never abandoned. Hold `wr_valid` until `wr_done`, ignore `wr_nack`, then go to IDLE.
- `go`=0 in DONE or FAIL: go to IDLE; `init_done`/`init_error` clear on the same edge.
- Re-assertion of `go` from IDLE restarts the table at index 0. This is the hot-plug re-init path.
- DONE and FAIL are held while `go`=1. FAIL never retries by itself.

Boundary and protocol rules:
- `wr_done` outside WAIT_DONE is ignored.
- `wr_nack` without `wr_done` is ignored.
- NUM_ENTRIES=1: first successful ack goes straight to DONE.
- `init_done` and `init_error` are never both 1.
- Asynchronous reset low mid-transaction: all outputs go to reset values immediately, regardless of the I2C master.

Test Plan:
1. hpd=1 from t0; `ready` rises at cycle 100; master acks every write with `wr_done` 2 cycles after `wr_valid`; NUM_ENTRIES=4 with ROM {0x4110,0x9803,0x9AE0,0xAF16} → first `wr_valid` at cycle 103; writes appear in order with matching `wr_reg`/`wr_data`; `init_done`=1 after the 4th ack; `init_error`=0 throughout.
2. Entry 1 NACKed once, then acked; RETRY_DELAY=5 → `wr_valid` low for exactly 5 cycles between attempts; the second attempt carries the same reg/data; the sequence completes with `init_done`=1.
3. Entry 2 NACKed every time; MAX_RETRIES=3 → exactly 3 attempts; then `init_error`=1, `init_done`=0, `wr_valid` stays 0; drop `hpd` → `init_error` clears after sync latency + 1.
4. Drop `ready` while in WAIT_DONE on entry 0 → `wr_valid` held until `wr_done`; then IDLE with no further writes. Raise `ready` again → restart at `tbl_addr`=0.
5. After DONE, toggle `hpd` low for 10 cycles, then high → `init_done` falls; the full table is rewritten from index 0; `init_done` rises again.
6. Assert `reset`=0 asynchronously mid-BACKOFF → `wr_valid`, `init_done`, `init_error`, `tbl_addr` all 0 before the next clock edge. Spurious `wr_done` pulses while in IDLE or DONE → no state change.
